// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tri-state bus controller slice.
package tri_bus_pkg;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned NREQ  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RECOVER,
    ST_RD_TURN,
    ST_RD_SAMPLE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, last-granted flop advanced on accept.
module rr_arb2
  import tri_bus_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

  logic            r_last;
  logic [NREQ-1:0] w_eff;

  assign w_eff = req & ~mask;

  // On a tie the requester that did not win last time takes the bus.
  always_comb begin
    grant = '0;
    case (w_eff)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = r_last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (advance) begin
      r_last <= grant[1];
    end
  end

endmodule

// File: rtl/tri_bus_ctrl.sv
// Arbitrated controller for a shared 8-bit bidirectional bus with turnaround
// idle cycles around every write and before every read sample.
module tri_bus_ctrl
  import tri_bus_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_we,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              oe,
  inout  logic [7:0]        io_pin
);

  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

  state_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic            r_gnt_idx;
  logic            r_we;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rdata;
  logic [NREQ-1:0] r_done;
  logic            r_rvalid;
  logic            r_busy;
  logic            r_oe;

  logic [NREQ-1:0] w_grant;
  logic            w_take;
  logic            w_sel;
  logic [7:0]      w_wbyte;

  // A requester whose done is showing this cycle sits out arbitration once.
  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .mask    (r_done),
    .advance (w_take),
    .grant   (w_grant)
  );

  assign w_take  = (r_state == ST_IDLE) && (|w_grant);
  assign w_sel   = w_grant[1];
  assign w_wbyte = w_sel ? req_wdata[15:8] : req_wdata[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_gnt_idx <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_done    <= '0;
      r_rvalid  <= 1'b0;
      r_busy    <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      r_done   <= '0;
      r_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_gnt_idx <= w_sel;
            r_we      <= req_we[w_sel];
            r_wdata   <= w_wbyte;
            r_busy    <= 1'b1;
            if (req_we[w_sel]) begin
              r_state <= ST_WRITE;
              r_oe    <= 1'b1;
            end else begin
              r_state <= ST_RD_TURN;
              r_cnt   <= TURN_LOAD;
            end
          end
        end
        ST_WRITE: begin
          r_oe    <= 1'b0;
          r_state <= ST_RECOVER;
          r_cnt   <= TURN_LOAD;
        end
        ST_RECOVER: begin
          if (r_cnt == '0) begin
            r_state           <= ST_IDLE;
            r_busy            <= 1'b0;
            r_done[r_gnt_idx] <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RD_TURN: begin
          if (r_cnt == '0) begin
            r_state <= ST_RD_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RD_SAMPLE: begin
          r_rdata           <= io_pin;
          r_rvalid          <= ~r_we;
          r_state           <= ST_IDLE;
          r_busy            <= 1'b0;
          r_done[r_gnt_idx] <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign io_pin = r_oe ? r_wdata : 'z;

  assign done   = r_done;
  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign busy   = r_busy;
  assign oe     = r_oe;

endmodule

// File: tb/tb_tri_bus_ctrl.sv
// Directed bench for tri_bus_ctrl: instance A with TURN_CYCLES=1, B with TURN_CYCLES=2.
module tb_tri_bus_ctrl;

  logic        clk;
  logic        reset;

  logic [1:0]  a_req, a_we, a_done;
  logic [15:0] a_wdata;
  logic [7:0]  a_rdata, a_drv;
  logic        a_rvalid, a_busy, a_oe, a_drv_en;
  wire  [7:0]  a_bus;

  logic [1:0]  b_req, b_we, b_done;
  logic [15:0] b_wdata;
  logic [7:0]  b_rdata, b_drv;
  logic        b_rvalid, b_busy, b_oe, b_drv_en;
  wire  [7:0]  b_bus;

  int unsigned n_checks;
  int unsigned n_fail;

  // External devices only drive while the controller has released the bus.
  assign a_bus = (a_drv_en && !a_oe) ? a_drv : 'z;
  assign b_bus = (b_drv_en && !b_oe) ? b_drv : 'z;

  tri_bus_ctrl #(.TURN_CYCLES(1)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .req       (a_req),
    .req_we    (a_we),
    .req_wdata (a_wdata),
    .done      (a_done),
    .rdata     (a_rdata),
    .rvalid    (a_rvalid),
    .busy      (a_busy),
    .oe        (a_oe),
    .io_pin    (a_bus)
  );

  tri_bus_ctrl #(.TURN_CYCLES(2)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req       (b_req),
    .req_we    (b_we),
    .req_wdata (b_wdata),
    .done      (b_done),
    .rdata     (b_rdata),
    .rvalid    (b_rvalid),
    .busy      (b_busy),
    .oe        (b_oe),
    .io_pin    (b_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  wr_log[$];
    int unsigned ndone, nd0, nd1, viol, low_run, min_gap, nwr;
    logic        prev_oe;

    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    a_req = '0; a_we = '0; a_wdata = '0; a_drv = '0; a_drv_en = 1'b0;
    b_req = '0; b_we = '0; b_wdata = '0; b_drv = '0; b_drv_en = 1'b0;

    #2;
    check_eq("rst_a_oe",     16'(a_oe),     16'h0);
    check_eq("rst_a_busy",   16'(a_busy),   16'h0);
    check_eq("rst_a_done",   16'(a_done),   16'h0);
    check_eq("rst_a_rvalid", 16'(a_rvalid), 16'h0);
    check_eq("rst_b_rdata",  16'(b_rdata),  16'h00);
    check_eq("rst_b_oe",     16'(b_oe),     16'h0);

    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single write, TURN_CYCLES=1: done three cycles after the request is seen.
    a_req = 2'b01; a_we = 2'b01; a_wdata = 16'h00A5;
    tick();
    check_eq("wr1_oe",    16'(a_oe),   16'h1);
    check_eq("wr1_bus",   16'(a_bus),  16'hA5);
    check_eq("wr1_busy",  16'(a_busy), 16'h1);
    check_eq("wr1_nodone",16'(a_done), 16'h0);
    tick();
    check_eq("wr1_rec_oe",16'(a_oe),   16'h0);
    check_eq("wr1_rec_dn",16'(a_done), 16'h0);
    tick();
    check_eq("wr1_done",  16'(a_done), 16'h1);
    check_eq("wr1_idle",  16'(a_busy), 16'h0);
    a_req = 2'b00;
    tick();
    check_eq("wr1_pulse", 16'(a_done), 16'h0);
    check_eq("wr1_nogrant",16'(a_busy),16'h0);

    // Single read, TURN_CYCLES=2: done four cycles after the request is seen.
    b_drv_en = 1'b1; b_drv = 8'h3C;
    b_req = 2'b10; b_we = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rd_busy",   16'(b_busy),   16'h1);
      check_eq("rd_oe",     16'(b_oe),     16'h0);
      check_eq("rd_nodone", 16'(b_done),   16'h0);
      check_eq("rd_norv",   16'(b_rvalid), 16'h0);
      check_eq("rd_hold",   16'(b_rdata),  16'h00);
    end
    tick();
    check_eq("rd_rdata",  16'(b_rdata),  16'h3C);
    check_eq("rd_rvalid", 16'(b_rvalid), 16'h1);
    check_eq("rd_done",   16'(b_done),   16'h2);
    check_eq("rd_idle",   16'(b_busy),   16'h0);
    b_req = 2'b00; b_drv = 8'h77;
    tick();
    check_eq("rd_rv_pulse", 16'(b_rvalid), 16'h0);
    check_eq("rd_dn_pulse", 16'(b_done),   16'h0);
    check_eq("rd_keep",     16'(b_rdata),  16'h3C);

    // Write with TURN_CYCLES=2: two oe-low recover cycles.
    b_drv_en = 1'b0;
    b_req = 2'b01; b_we = 2'b01; b_wdata = 16'h0096;
    tick();
    check_eq("wr2_oe",   16'(b_oe),   16'h1);
    check_eq("wr2_bus",  16'(b_bus),  16'h96);
    tick();
    check_eq("wr2_rec1", 16'(b_oe),   16'h0);
    tick();
    check_eq("wr2_rec2", 16'(b_oe),   16'h0);
    check_eq("wr2_nodn", 16'(b_done), 16'h0);
    tick();
    check_eq("wr2_done", 16'(b_done), 16'h1);
    check_eq("wr2_keep", 16'(b_rdata),16'h3C);
    b_req = 2'b00;

    // Tie after reset: requester 0 first.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    a_req = 2'b11; a_we = 2'b11; a_wdata = 16'h2211;
    tick();
    check_eq("tie_oe0",   16'(a_oe),   16'h1);
    check_eq("tie_bus0",  16'(a_bus),  16'h11);
    tick();
    check_eq("tie_gap",   16'(a_oe),   16'h0);
    tick();
    check_eq("tie_done0", 16'(a_done), 16'h1);
    check_eq("tie_gap2",  16'(a_oe),   16'h0);
    a_req = 2'b10;
    tick();
    check_eq("tie_oe1",   16'(a_oe),   16'h1);
    check_eq("tie_bus1",  16'(a_bus),  16'h22);
    check_eq("tie_dn_off",16'(a_done), 16'h0);
    tick();
    check_eq("tie_rec1",  16'(a_oe),   16'h0);
    tick();
    check_eq("tie_done1", 16'(a_done), 16'h2);
    a_req = 2'b00;
    tick();
    check_eq("tie_once",  16'(a_done), 16'h0);
    check_eq("tie_idle",  16'(a_busy), 16'h0);

    // Fairness: both hold requests for six transactions.
    a_req = 2'b11; a_we = 2'b11; a_wdata = 16'h2211;
    ndone = 0; nd0 = 0; nd1 = 0; viol = 0; low_run = 0; min_gap = 99; nwr = 0;
    prev_oe = 1'b0;
    for (int c = 0; c < 60 && ndone < 6; c++) begin
      tick();
      if (a_oe) begin
        if (prev_oe) viol++;
        if (nwr > 0 && low_run < min_gap) min_gap = low_run;
        wr_log.push_back(a_bus);
        nwr++;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_oe = a_oe;
      if (a_done[0]) nd0++;
      if (a_done[1]) nd1++;
      if (a_done != 2'b00) begin
        ndone++;
        if (ndone == 6) a_req = 2'b00;
      end
    end
    check_eq("fair_ndone", 16'(ndone), 16'd6);
    check_eq("fair_nd0",   16'(nd0),   16'd3);
    check_eq("fair_nd1",   16'(nd1),   16'd3);
    check_eq("fair_nlog",  16'(wr_log.size()), 16'd6);
    for (int i = 0; i < 6 && i < int'(wr_log.size()); i++) begin
      check_eq("fair_order", 16'(wr_log[i]), (i % 2 == 0) ? 16'h11 : 16'h22);
    end
    check_eq("fair_oe_consec", 16'(viol), 16'd0);
    check_eq("fair_min_gap",   16'(min_gap >= 1), 16'h1);
    tick();
    check_eq("fair_stop", 16'(a_busy), 16'h0);

    // Reset while oe is high: asynchronous release of the bus, no done.
    a_req = 2'b01; a_we = 2'b01; a_wdata = 16'h00C3;
    tick();
    check_eq("rstw_oe_pre", 16'(a_oe), 16'h1);
    #1 reset = 1'b1;
    a_drv = 8'h5A; a_drv_en = 1'b1;
    #1;
    check_eq("rstw_oe",   16'(a_oe),   16'h0);
    check_eq("rstw_hiz",  16'(a_bus),  16'h5A);
    check_eq("rstw_busy", 16'(a_busy), 16'h0);
    tick();
    check_eq("rstw_nodn", 16'(a_done), 16'h0);
    a_drv_en = 1'b0;
    reset = 1'b0;
    tick();
    check_eq("rstw_regrant", 16'(a_oe),  16'h1);
    check_eq("rstw_bus",     16'(a_bus), 16'hC3);
    tick();
    check_eq("rstw_rec",     16'(a_oe),  16'h0);
    tick();
    check_eq("rstw_done",    16'(a_done),16'h1);
    a_req = 2'b00;
    tick();
    check_eq("rstw_pulse",   16'(a_done),16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_bus_ctrl.md
TRI_BUS_CTRL -- requirements
Module: tri_bus_ctrl

Interface
REQ-001 Parameter TURN_CYCLES, default 1, sets the bus-turnaround idle cycles with oe low; legal range is 1..7.
REQ-002 Port clk, input, 1 bit, is the system clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, is the asynchronous, active-high reset.
REQ-004 Port req, input, 2 bits, is the per-requester transaction request (level), held until that requester's done.
REQ-005 Port req_we, input, 2 bits, selects the transaction per requester: 1 = write to bus, 0 = read from bus.
REQ-006 Port req_wdata, input, 16 bits, carries write data: requester 0 on [7:0], requester 1 on [15:8].
REQ-007 Port done, output, 2 bits, is a one-cycle completion pulse per requester.
REQ-008 Port rdata, output, 8 bits, holds the last sampled bus value.
REQ-009 Port rvalid, output, 1 bit, is a one-cycle pulse marking rdata as new.
REQ-010 Port busy, output, 1 bit, is high whenever the FSM is not in IDLE.
REQ-011 Port oe, output, 1 bit, is the registered drive enable, exported for observation.
REQ-012 Port io_pin, inout, 8 bits, is the shared bidirectional bus, driven only while oe=1 and high-Z otherwise.

Function
REQ-013 The FSM states shall be IDLE, WRITE, RECOVER, RD_TURN and RD_SAMPLE.
REQ-014 In IDLE with any unmasked req, the block shall grant one requester and latch its index, req_we and wdata byte; the captured values stay stable until done.
REQ-015 Arbitration shall be round-robin over 2 requesters: if both request, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-016 A grant with we=1 shall go IDLE->WRITE; WRITE lasts exactly 1 cycle with oe=1 and io_pin=latched byte.
REQ-017 WRITE shall go to RECOVER; RECOVER lasts TURN_CYCLES cycles with oe=0, then returns to IDLE.
REQ-018 A grant with we=0 shall go IDLE->RD_TURN; RD_TURN lasts TURN_CYCLES cycles with oe=0.
REQ-019 RD_TURN shall go to RD_SAMPLE (1 cycle, oe=0); on its closing edge io_pin is registered into rdata and the FSM returns to IDLE.
REQ-020 done[g] shall be high for exactly the first IDLE cycle after a transaction of granted requester g; for reads, rvalid shall be high in that same cycle.
REQ-021 During a done[g] cycle, req[g] shall be masked from arbitration; the other requester may be granted in that cycle.
REQ-022 oe shall be a flop output, never high outside WRITE; consecutive writes are always separated by at least TURN_CYCLES oe-low cycles.
REQ-023 Write latency from req seen in IDLE to done shall be 2+TURN_CYCLES cycles; read latency shall be 2+TURN_CYCLES cycles.
REQ-024 The turnaround counter shall be 3 bits, load TURN_CYCLES-1 on state entry, count down to 0, and never wrap.
REQ-025 Requests arriving while busy=1 shall wait; no request is dropped or reordered beyond the round-robin rule.
REQ-026 rdata shall change only on RD_SAMPLE exit and hold its value otherwise.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, oe=0 (io_pin high-Z), done=0, rvalid=0, rdata=8'h00, busy=0, round-robin pointer = requester 1 last-granted, counter=0.
REQ-028 Reset mid-transaction shall abort it with no done pulse; after release the requester must still see a fresh grant.

Structure
REQ-029 Package tri_bus_pkg shall hold the FSM state enum, the counter width constant (3) and the requester count constant (2).
REQ-030 The round-robin grant logic shall be a sub-module rr_arb2 (inputs req, mask, advance; output one-hot grant; internal last-grant flop).
REQ-031 The tri-state assignment shall exist only in tri_bus_ctrl top level; the bench models the external device with its own oe-gated driver.

Verification
REQ-032 Single write: TURN_CYCLES=1, req=01, we=01, wdata[7:0]=8'hA5 -> io_pin=8'hA5 with oe=1 for one cycle; done=01 three cycles after the request is seen.
REQ-033 Single read: TURN_CYCLES=2, req=10, we=00, bench drives 8'h3C while oe=0 -> rdata=8'h3C, rvalid=1, done=10 four cycles after request.
REQ-034 Tie after reset: req=11, both writes (8'h11, 8'h22) -> 8'h11 appears on io_pin first, then 8'h22, with TURN_CYCLES oe-low cycles between; both done pulses once.
REQ-035 Fairness: both requesters hold req for 6 transactions -> grants alternate 0,1,0,1,0,1; oe never high two consecutive cycles.
REQ-036 Reset mid-WRITE: assert reset while oe=1 -> oe=0 and io_pin high-Z immediately (asynchronous), no done pulse; after release a held req is re-granted and completes normally.
